count_checker: RTL and testbench

- Receive-side counterpart of the count feeder: drains the FT600 245-mode RX FIFO and checks that each word follows the count pattern.
- Count pattern: low byte = v, high byte = v+1 (mod 256); the next word has v+2.
- Sits between the ft600_mode245 RX port and the top-level LEDs.
- Provides lock/error status and counters for host-to-FPGA loopback and throughput testing.

---
 rtl/count_checker_if.sv | 31 +++
 rtl/count_checker.sv | 195 +++++++++++++++++++
 tb/tb_count_checker.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/count_checker_if.sv
// count_checker_if
//
// Read side of the FT600 245-mode RX FIFO.
//
// Handshake: the master raises rx_en for one cycle per word it consumes,
// and only while rx_empty is low. The FIFO pops on that clock edge and
// presents the popped word on rx_out for the whole following cycle. It also
// updates rx_empty on that edge, so a master that checks rx_empty every
// cycle can read back-to-back without underflowing.
//
// Signals:
//   rx_en    master -> slave  read strobe, one word per high cycle
//   rx_out   slave  -> master read data, valid the cycle after rx_en
//   rx_empty slave  -> master FIFO empty flag
interface count_checker_if;
    logic        rx_en;
    logic [15:0] rx_out;
    logic        rx_empty;

    modport master (
        output rx_en,
        input  rx_out,
        input  rx_empty
    );

    modport slave (
        input  rx_en,
        output rx_out,
        output rx_empty
    );
endinterface

// File: rtl/count_checker.sv
// count_checker
//
// Drains the FT600 RX FIFO and checks that the words follow the count
// pattern: low byte v, high byte v+1 (mod 256), next word starts at v+2.
// Reports lock state, per-word error pulses, saturating error count,
// wrapping word count, the last bad word and an LED summary.
//
// Optional build macro COUNT_CHECKER_THROTTLE_EN: when defined, a
// free-running THROTTLE_LOG2-bit tick counter allows at most one read every
// 2**THROTTLE_LOG2 cycles, so the FIFO fills and FT600 back-pressure is
// exercised. When undefined, reads run at one word per clock.
//
// Parameters:
//   CNT_WIDTH      width of word_count / err_count (>= 6)
//   THROTTLE_LOG2  read spacing exponent (throttled build only, >= 1)
//
// Ports:
//   clk        system clock, same domain as the FT600 user side
//   rst_n      asynchronous active-low reset
//   rx         count_checker_if.master, FIFO read port
//   locked     checker is synchronised to the pattern
//   err_pulse  one-cycle pulse per mismatching word
//   err_count  mismatches since reset, saturating
//   word_count words consumed since reset, wrapping
//   last_bad   most recent mismatching word
//   led        {word_count top 6 bits, sticky error, locked}
//   dbg_state  FSM state (0 = HUNT, 1 = LOCKED)
module count_checker #(
    parameter int CNT_WIDTH     = 16,
    parameter int THROTTLE_LOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    count_checker_if.master      rx,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [15:0]          last_bad,
    output logic [7:0]           led,
    output logic                 dbg_state
);

    // Parameter sanity: LED slice needs six counter bits and the tick
    // counter needs at least one bit.
    if (CNT_WIDTH < 6 || THROTTLE_LOG2 < 1) begin : g_bad_params
        $error("count_checker: CNT_WIDTH must be >= 6 and THROTTLE_LOG2 >= 1");
    end

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic       rd_v;
    logic [7:0] expected;
    logic       sticky_err;

    logic       well_formed;
    logic       in_sequence;
    logic       word_bad;
    logic       advance;

    // ------------------------------------------------------------------
    // Read issue
    // ------------------------------------------------------------------
`ifdef COUNT_CHECKER_THROTTLE_EN
    logic [THROTTLE_LOG2-1:0] tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= '0;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // tick is cleared asynchronously, so it cannot be all-ones in reset.
    always_comb begin
        rx.rx_en = ~rx.rx_empty & (&tick);
    end
`else
    always_comb begin
        rx.rx_en = ~rx.rx_empty & rst_n;
    end
`endif

    // rd_v marks the cycle in which rx_out carries the word just popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v <= 1'b0;
        end else begin
            rd_v <= rx.rx_en;
        end
    end

    // ------------------------------------------------------------------
    // Word tests
    // ------------------------------------------------------------------
    always_comb begin
        well_formed = (rx.rx_out[15:8] == (rx.rx_out[7:0] + 8'd1));
        in_sequence = well_formed && (rx.rx_out[7:0] == expected);
        word_bad    = rd_v && (state_q == LOCKED) && !in_sequence;
        // Either the first good word in HUNT or a continuing word in
        // LOCKED moves the expected low byte on by two.
        advance     = rd_v && (((state_q == HUNT) && well_formed) ||
                               ((state_q == LOCKED) && in_sequence));
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (rd_v) begin
            case (state_q)
                HUNT: begin
                    if (well_formed) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    if (!in_sequence) begin
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded straight from the state register)
    // ------------------------------------------------------------------
    always_comb begin
        locked    = (state_q == LOCKED);
        dbg_state = state_q;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected <= 8'd0;
        end else if (advance) begin
            expected <= rx.rx_out[7:0] + 8'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse  <= 1'b0;
            err_count  <= '0;
            last_bad   <= 16'd0;
            sticky_err <= 1'b0;
        end else begin
            err_pulse <= word_bad;
            if (word_bad) begin
                last_bad   <= rx.rx_out;
                sticky_err <= 1'b1;
                if (err_count != {CNT_WIDTH{1'b1}}) begin
                    err_count <= err_count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
        end else if (rd_v) begin
            word_count <= word_count + 1'b1;
        end
    end

    always_comb begin
        led = {word_count[CNT_WIDTH-1 -: 6], sticky_err, locked};
    end

endmodule

// File: tb/tb_count_checker.sv
module tb_count_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] word_count;
    logic [15:0] last_bad;
    logic [7:0]  led;
    logic        dbg_state;

    int checks = 0;
    int failures = 0;

    int en_cnt = 0;
    int pulse_cnt = 0;

    logic [15:0] feed_q[$];

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    always #5 clk = ~clk;

    count_checker_if rx_if ();

    count_checker #(
        .CNT_WIDTH     (16),
        .THROTTLE_LOG2 (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx_if.master),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .word_count (word_count),
        .last_bad   (last_bad),
        .led        (led),
        .dbg_state  (dbg_state)
    );

    // Event counters used for "how many cycles was X high" checks.
    always @(posedge clk) begin
        if (rx_if.rx_en) en_cnt <= en_cnt + 1;
        if (err_pulse)   pulse_cnt <= pulse_cnt + 1;
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        rx_if.rx_empty = 1'b1;
        rx_if.rx_out = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Plays a FIFO holding feed_q. Returns 1 ns after the edge that popped
    // the last word, i.e. in the cycle where the DUT's rd_v is high for it.
    task automatic feed();
        int  idx;
        int  guard;
        int  limit;
        bit  took;
        idx = 0;
        guard = 0;
        limit = 64 * feed_q.size() + 64;
        while (idx < feed_q.size() && guard < limit) begin
            @(negedge clk);
            rx_if.rx_empty = 1'b0;
            #1;
            took = rx_if.rx_en;
            @(posedge clk);
            #1;
            if (took) begin
                rx_if.rx_out = feed_q[idx];
                idx++;
            end
            guard++;
        end
        rx_if.rx_empty = 1'b1;
        checks++;
        if (idx != feed_q.size()) begin
            failures++;
            $display("FAIL feed_timeout: consumed %0d words, required %0d", idx, feed_q.size());
        end
        feed_q.delete();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        repeat (3) settle();
        checks++;
        if (rx_if.rx_en !== 1'b0) begin
            failures++; $display("FAIL reset_rx_en: got %0b required 0", rx_if.rx_en);
        end
        checks++;
        if (locked !== 1'b0) begin
            failures++; $display("FAIL reset_locked: got %0b required 0", locked);
        end
        checks++;
        if (err_pulse !== 1'b0) begin
            failures++; $display("FAIL reset_err_pulse: got %0b required 0", err_pulse);
        end
        checks++;
        if (err_count !== 16'd0) begin
            failures++; $display("FAIL reset_err_count: got %0h required 0", err_count);
        end
        checks++;
        if (word_count !== 16'd0) begin
            failures++; $display("FAIL reset_word_count: got %0h required 0", word_count);
        end
        checks++;
        if (last_bad !== 16'd0) begin
            failures++; $display("FAIL reset_last_bad: got %0h required 0", last_bad);
        end
        checks++;
        if (led !== 8'h00) begin
            failures++; $display("FAIL reset_led: got %0h required 00", led);
        end
        checks++;
        if (dbg_state !== 1'b0) begin
            failures++; $display("FAIL reset_state: got %0b required 0", dbg_state);
        end
    endtask

    task automatic test_lock_latency();
        apply_reset();
        feed_q.push_back(16'h0100);
        feed();
        // rd_v is high now; the check result lands on the next edge.
        checks++;
        if (locked !== 1'b0) begin
            failures++; $display("FAIL lock_early: got %0b required 0", locked);
        end
        settle();
        checks++;
        if (locked !== 1'b1) begin
            failures++; $display("FAIL lock_after_one: got %0b required 1", locked);
        end
    endtask

    task automatic test_basic();
        int en0;
        apply_reset();
        en0 = en_cnt;
        feed_q.push_back(16'h0100);
        feed_q.push_back(16'h0302);
        feed_q.push_back(16'h0504);
        feed();
        settle();
        checks++;
        if (en_cnt - en0 !== 3) begin
            failures++; $display("FAIL basic_rx_en_cycles: got %0d required 3", en_cnt - en0);
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++; $display("FAIL basic_locked: got %0b required 1", locked);
        end
        checks++;
        if (word_count !== 16'd3) begin
            failures++; $display("FAIL basic_word_count: got %0d required 3", word_count);
        end
        checks++;
        if (err_count !== 16'd0) begin
            failures++; $display("FAIL basic_err_count: got %0d required 0", err_count);
        end
        checks++;
        if (led !== 8'h01) begin
            failures++; $display("FAIL basic_led: got %0h required 01", led);
        end
    endtask

    // Continues from test_basic: locked with expected low byte 0x06.
    task automatic test_error();
        int p0;
        p0 = pulse_cnt;
        feed_q.push_back(16'h0908);
        feed();
        settle();
        checks++;
        if (err_pulse !== 1'b1) begin
            failures++; $display("FAIL err_pulse_high: got %0b required 1", err_pulse);
        end
        checks++;
        if (err_count !== 16'd1) begin
            failures++; $display("FAIL err_count_one: got %0d required 1", err_count);
        end
        checks++;
        if (last_bad !== 16'h0908) begin
            failures++; $display("FAIL err_last_bad: got %0h required 0908", last_bad);
        end
        checks++;
        if (locked !== 1'b0) begin
            failures++; $display("FAIL err_unlocked: got %0b required 0", locked);
        end
        checks++;
        if (led[1] !== 1'b1) begin
            failures++; $display("FAIL err_sticky_led: got %0b required 1", led[1]);
        end
        settle();
        checks++;
        if (err_pulse !== 1'b0) begin
            failures++; $display("FAIL err_pulse_one_cycle: got %0b required 0", err_pulse);
        end
        feed_q.push_back(16'h0B0A);
        feed();
        settle();
        checks++;
        if (locked !== 1'b1) begin
            failures++; $display("FAIL err_relock: got %0b required 1", locked);
        end
        checks++;
        if (err_count !== 16'd1) begin
            failures++; $display("FAIL err_relock_count: got %0d required 1", err_count);
        end
        checks++;
        if (pulse_cnt - p0 !== 1) begin
            failures++; $display("FAIL err_pulse_total: got %0d required 1", pulse_cnt - p0);
        end
        checks++;
        if (word_count !== 16'd5) begin
            failures++; $display("FAIL err_word_count: got %0d required 5", word_count);
        end
        checks++;
        if (led[1] !== 1'b1) begin
            failures++; $display("FAIL err_sticky_held: got %0b required 1", led[1]);
        end
    endtask

    task automatic test_consecutive_bad();
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        feed_q.push_back(16'h0100);
        feed_q.push_back(16'h5555);
        feed_q.push_back(16'h6666);
        feed();
        repeat (3) settle();
        checks++;
        if (pulse_cnt - p0 !== 1) begin
            failures++; $display("FAIL consec_pulses: got %0d required 1", pulse_cnt - p0);
        end
        checks++;
        if (err_count !== 16'd1) begin
            failures++; $display("FAIL consec_err_count: got %0d required 1", err_count);
        end
        checks++;
        if (last_bad !== 16'h5555) begin
            failures++; $display("FAIL consec_last_bad: got %0h required 5555", last_bad);
        end
        checks++;
        if (dbg_state !== 1'b0) begin
            failures++; $display("FAIL consec_state: got %0b required 0", dbg_state);
        end
    endtask

    task automatic test_hunt_malformed();
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        feed_q.push_back(16'h1234);
        feed();
        repeat (2) settle();
        checks++;
        if (pulse_cnt - p0 !== 0) begin
            failures++; $display("FAIL hunt_pulse: got %0d required 0", pulse_cnt - p0);
        end
        checks++;
        if (locked !== 1'b0) begin
            failures++; $display("FAIL hunt_locked: got %0b required 0", locked);
        end
        checks++;
        if (word_count !== 16'd1) begin
            failures++; $display("FAIL hunt_word_count: got %0d required 1", word_count);
        end
        checks++;
        if (err_count !== 16'd0) begin
            failures++; $display("FAIL hunt_err_count: got %0d required 0", err_count);
        end
        // 0x00FF is well-formed (high byte wraps), expected becomes 0x01.
        feed_q.push_back(16'h00FF);
        feed_q.push_back(16'h0201);
        feed();
        settle();
        checks++;
        if (locked !== 1'b1 || err_count !== 16'd0) begin
            failures++; $display("FAIL hunt_00ff_lock: got locked=%0b errs=%0d required locked=1 errs=0", locked, err_count);
        end
    endtask

    task automatic test_wrap();
        int p0;
        apply_reset();
        p0 = pulse_cnt;
        feed_q.push_back(16'hFDFC);
        feed_q.push_back(16'hFFFE);
        feed_q.push_back(16'h0100);
        feed_q.push_back(16'h0302);
        feed();
        settle();
        checks++;
        if (pulse_cnt - p0 !== 0 || err_count !== 16'd0) begin
            failures++; $display("FAIL wrap_errors: got pulses=%0d errs=%0d required 0", pulse_cnt - p0, err_count);
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++; $display("FAIL wrap_locked: got %0b required 1", locked);
        end
        checks++;
        if (word_count !== 16'd4) begin
            failures++; $display("FAIL wrap_word_count: got %0d required 4", word_count);
        end
    endtask

    task automatic test_led_bits();
        logic [7:0] v;
        apply_reset();
        v = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            feed_q.push_back({v + 8'd1, v});
            v = v + 8'd2;
        end
        feed();
        settle();
        checks++;
        if (word_count !== 16'd1024) begin
            failures++; $display("FAIL led_word_count: got %0d required 1024", word_count);
        end
        checks++;
        if (led !== 8'h05) begin
            failures++; $display("FAIL led_pattern: got %0h required 05", led);
        end
        checks++;
        if (err_count !== 16'd0) begin
            failures++; $display("FAIL led_err_count: got %0d required 0", err_count);
        end
    endtask

`ifdef COUNT_CHECKER_THROTTLE_EN
    task automatic test_throttle();
        int en0;
        rst_n = 1'b0;
        rx_if.rx_empty = 1'b0;
        rx_if.rx_out = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en0 = en_cnt;
        repeat (64) @(posedge clk);
        #1;
        checks++;
        if (en_cnt - en0 !== 4) begin
            failures++; $display("FAIL throttle_reads: got %0d required 4", en_cnt - en0);
        end
        settle();
        checks++;
        if (word_count !== 16'd4) begin
            failures++; $display("FAIL throttle_word_count: got %0d required 4", word_count);
        end
        rx_if.rx_empty = 1'b1;
    endtask
`endif

    task automatic test_reset_midstream();
        apply_reset();
        feed_q.push_back(16'h0100);
        feed_q.push_back(16'h0302);
        feed();
        settle();
        feed_q.push_back(16'h0504);
        feed();
        // rd_v is high for 0x0504 right now.
        rst_n = 1'b0;
        #1;
        checks++;
        if (word_count !== 16'd0) begin
            failures++; $display("FAIL mid_word_count: got %0d required 0", word_count);
        end
        checks++;
        if (locked !== 1'b0) begin
            failures++; $display("FAIL mid_locked: got %0b required 0", locked);
        end
        checks++;
        if (led !== 8'h00) begin
            failures++; $display("FAIL mid_led: got %0h required 00", led);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) settle();
        checks++;
        if (word_count !== 16'd0) begin
            failures++; $display("FAIL mid_pending_dropped: got %0d required 0", word_count);
        end
        feed_q.push_back(16'h0706);
        feed();
        settle();
        checks++;
        if (locked !== 1'b1 || word_count !== 16'd1) begin
            failures++; $display("FAIL mid_restart: got locked=%0b count=%0d required locked=1 count=1", locked, word_count);
        end
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        rx_if.rx_empty = 1'b1;
        rx_if.rx_out = 16'h0000;
        apply_reset();
        test_reset();
        test_lock_latency();
        test_basic();
        test_error();
        test_consecutive_bad();
        test_hunt_malformed();
        test_wrap();
        test_led_bits();
`ifdef COUNT_CHECKER_THROTTLE_EN
        test_throttle();
`endif
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
